// File: rtl/viola_pkg.sv
// Shared writeback types and constants for the execution-unit to ROB path.
package viola_pkg;

    localparam int TAG_W_DEF  = 3;
    localparam int DATA_W_DEF = 32;

    // Tag value meaning "no result"
    localparam int NO_TAG = 0;

    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_MEM = 1'b1;

    typedef struct packed {
        logic [TAG_W_DEF-1:0]  tag;
        logic [DATA_W_DEF-1:0] value;
        logic                  is_branch;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small per-producer result queue. Head is read combinationally so the arbiter
// can pop and register it in the same cycle. A push into a full queue is dropped.
module wb_fifo
    import viola_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = wb_entry_t
) (
    input  logic   clk,
    input  logic   clear,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t head,
    output logic   empty,
    output logic   full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    entry_t           mem_reg [DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    // Fullness is judged at the start of the cycle; a same-cycle pop does not make room.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_reg[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter between ALU and memory unit into the single ROB port.
// Optional same-cycle bypass of empty queues is enabled by defining WB_ARB_BYPASS_EN.
module wb_arbiter
    import viola_pkg::*;
#(
    parameter int TAG_W  = TAG_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [TAG_W-1:0]  alu_num,
    input  logic [DATA_W-1:0] alu_value,
    input  logic              alu_is_branch,
    input  logic [TAG_W-1:0]  mem_num,
    input  logic [DATA_W-1:0] mem_value,
    output logic              alu_stall,
    output logic              mem_stall,
    output logic [TAG_W-1:0]  wb_num,
    output logic [DATA_W-1:0] wb_value,
    output logic              wb_is_branch,
    output logic              wb_src,
    output logic              overflow
);

    localparam int NUM_SRC = 2;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] value;
        logic              is_branch;
    } entry_t;

    entry_t               in_entry   [NUM_SRC];
    entry_t               fifo_head  [NUM_SRC];
    logic [NUM_SRC-1:0]   in_valid;
    logic [NUM_SRC-1:0]   fifo_empty;
    logic [NUM_SRC-1:0]   fifo_full;
    logic [NUM_SRC-1:0]   cand;
    logic [NUM_SRC-1:0]   bypass;
    logic [NUM_SRC-1:0]   push;
    logic [NUM_SRC-1:0]   pop;
    logic                 clear;
    logic                 grant_valid;
    logic                 grant_src;
    entry_t               grant_entry;
    logic                 overflow_set;

    entry_t               wb_reg;
    logic                 wb_src_reg;
    logic                 last_grant_reg;
    logic                 overflow_reg;

    assign clear = rst || flush;

    always_comb begin
        in_entry[SRC_ALU] = '{tag: alu_num, value: alu_value, is_branch: alu_is_branch};
        in_entry[SRC_MEM] = '{tag: mem_num, value: mem_value, is_branch: 1'b0};
    end

    // Results presented during a flush or reset cycle are discarded outright.
    assign in_valid[SRC_ALU] = (alu_num != TAG_W'(NO_TAG)) && !clear;
    assign in_valid[SRC_MEM] = (mem_num != TAG_W'(NO_TAG)) && !clear;

`ifdef WB_ARB_BYPASS_EN
    // An empty queue competes with the result being presented right now.
    assign cand = ~fifo_empty | in_valid;
`else
    assign cand = ~fifo_empty;
`endif

    always_comb begin
        grant_valid = |cand;
        grant_src   = SRC_ALU;
        if (&cand) begin
            grant_src = ~last_grant_reg;
        end else if (cand[SRC_MEM]) begin
            grant_src = SRC_MEM;
        end
    end

    always_comb begin
        grant_entry = bypass[grant_src] ? in_entry[grant_src] : fifo_head[grant_src];
    end

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        assign bypass[gi] = grant_valid && (grant_src == 1'(gi)) && fifo_empty[gi];
        assign pop[gi]    = grant_valid && (grant_src == 1'(gi)) && !fifo_empty[gi];
        assign push[gi]   = in_valid[gi] && !bypass[gi];

        wb_fifo #(
            .DEPTH   (DEPTH),
            .entry_t (entry_t)
        ) u_fifo (
            .clk       (clk),
            .clear     (clear),
            .push      (push[gi]),
            .push_data (in_entry[gi]),
            .pop       (pop[gi]),
            .head      (fifo_head[gi]),
            .empty     (fifo_empty[gi]),
            .full      (fifo_full[gi])
        );
    end

    assign overflow_set = |(push & fifo_full);

    always_ff @(posedge clk) begin
        if (clear) begin
            wb_reg     <= '0;
            wb_src_reg <= SRC_ALU;
            // A plain flush keeps the fairness pointer and the sticky error.
            if (rst) begin
                last_grant_reg <= SRC_MEM;
                overflow_reg   <= 1'b0;
            end
        end else begin
            if (grant_valid) begin
                wb_reg         <= grant_entry;
                wb_src_reg     <= grant_src;
                last_grant_reg <= grant_src;
            end else begin
                wb_reg.tag <= '0;
            end
            if (overflow_set) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign wb_num       = wb_reg.tag;
    assign wb_value     = wb_reg.value;
    assign wb_is_branch = wb_reg.is_branch;
    assign wb_src       = wb_src_reg;
    assign overflow     = overflow_reg;
    assign alu_stall    = fifo_full[SRC_ALU];
    assign mem_stall    = fifo_full[SRC_MEM];

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized and directed self-checking bench for wb_arbiter against a queue-based model.
module tb_wb_arbiter;

`ifdef WB_ARB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic [2:0]  alu_num, mem_num;
    logic [31:0] alu_value, mem_value;
    logic        alu_is_branch;
    logic        alu_stall, mem_stall;
    logic [2:0]  wb_num;
    logic [31:0] wb_value;
    logic        wb_is_branch, wb_src, overflow;

    wb_arbiter #(.TAG_W(3), .DATA_W(32), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .alu_num       (alu_num),
        .alu_value     (alu_value),
        .alu_is_branch (alu_is_branch),
        .mem_num       (mem_num),
        .mem_value     (mem_value),
        .alu_stall     (alu_stall),
        .mem_stall     (mem_stall),
        .wb_num        (wb_num),
        .wb_value      (wb_value),
        .wb_is_branch  (wb_is_branch),
        .wb_src        (wb_src),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        logic [31:0] value;
        bit          br;
    } ent_t;

    ent_t        aq[$];
    ent_t        mq[$];
    int          m_num;
    logic [31:0] m_val;
    bit          m_br, m_src, m_last, m_ovf;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model one clock from the arbitration rules, advance the DUT, then compare.
    task automatic step();
        ent_t e;
        bit   av, mv, a_full, m_full, a_used, m_used, ca, cm;
        int   win;
        av = (alu_num != 0);
        mv = (mem_num != 0);
        if (rst || flush) begin
            aq.delete();
            mq.delete();
            m_num = 0; m_val = 0; m_br = 0; m_src = 0;
            if (rst) begin
                m_last = 1;
                m_ovf  = 0;
            end
        end else begin
            a_full = (aq.size() == DEPTH);
            m_full = (mq.size() == DEPTH);
            ca = (aq.size() > 0) || (BYP && av);
            cm = (mq.size() > 0) || (BYP && mv);
            win = 0;
            if (ca && cm)  win = m_last ? 1 : 2;
            else if (ca)   win = 1;
            else if (cm)   win = 2;
            a_used = 0;
            m_used = 0;
            if (win == 1) begin
                if (aq.size() > 0) e = aq.pop_front();
                else begin
                    e = '{int'(alu_num), alu_value, alu_is_branch};
                    a_used = 1;
                end
                m_num = e.tag; m_val = e.value; m_br = e.br; m_src = 0; m_last = 0;
            end else if (win == 2) begin
                if (mq.size() > 0) e = mq.pop_front();
                else begin
                    e = '{int'(mem_num), mem_value, 1'b0};
                    m_used = 1;
                end
                m_num = e.tag; m_val = e.value; m_br = e.br; m_src = 1; m_last = 1;
            end else begin
                m_num = 0;
            end
            if (av && !a_used) begin
                if (a_full) m_ovf = 1;
                else aq.push_back('{int'(alu_num), alu_value, alu_is_branch});
            end
            if (mv && !m_used) begin
                if (m_full) m_ovf = 1;
                else mq.push_back('{int'(mem_num), mem_value, 1'b0});
            end
        end
        @(posedge clk);
        #1;
        if (wb_num != 0)
            $display("wb tag=%0d value=%08h branch=%0d src=%0d", wb_num, wb_value, wb_is_branch, wb_src);
        check("wb_num", wb_num, m_num);
        check("wb_value", wb_value, m_val);
        check("wb_is_branch", wb_is_branch, m_br);
        check("wb_src", wb_src, m_src);
        check("overflow", overflow, m_ovf);
        check("alu_stall", alu_stall, aq.size() == DEPTH);
        check("mem_stall", mem_stall, mq.size() == DEPTH);
    endtask

    task automatic idle();
        alu_num = 0; alu_value = 0; alu_is_branch = 0;
        mem_num = 0; mem_value = 0;
        flush = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        step();
        rst = 0;
    endtask

    // Steps idle cycles until a writeback appears (bounded), then checks its tag.
    task automatic await_wb(input string tag, input int exp);
        int n = 0;
        while (wb_num == 0 && n < 4) begin
            step();
            n++;
        end
        check(tag, wb_num, exp);
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_num"}, wb_num, 0);
        check({pfx, "_value"}, wb_value, 0);
        check({pfx, "_branch"}, wb_is_branch, 0);
        check({pfx, "_src"}, wb_src, 0);
        check({pfx, "_ovf"}, overflow, 0);
        check({pfx, "_astall"}, alu_stall, 0);
        check({pfx, "_mstall"}, mem_stall, 0);
    endtask

    initial begin
        rst = 1;
        idle();
        m_last = 1; m_ovf = 0; m_num = 0; m_val = 0; m_br = 0; m_src = 0;
        step();
        do_reset();
        check_reset_values("reset");

        // Single ALU result
        alu_num = 3; alu_value = 32'h10;
        step();
        idle();
        await_wb("t1_num", 3);
        check("t1_value", wb_value, 32'h10);
        check("t1_src", wb_src, 0);
        step();
        check("t1_after", wb_num, 0);

        // Collision from reset: ALU wins the first tie
        do_reset();
        alu_num = 2; mem_num = 5;
        step();
        idle();
        await_wb("t2_first", 2);
        step();
        check("t2_second", wb_num, 5);
        check("t2_second_src", wb_src, 1);

        // Fill the ALU queue, then force an extra result
        do_reset();
        for (int i = 0; i < 10 && !alu_stall; i++) begin
            alu_num = 3'(1 + i % 7); alu_value = $urandom;
            mem_num = mem_stall ? 3'd0 : 3'(7 - i % 7); mem_value = $urandom;
            step();
        end
        idle();
        check("t3_stall", alu_stall, 1);
        alu_num = 7; alu_value = 32'hdead;
        step();
        idle();
        check("t3_ovf", overflow, 1);
        for (int i = 0; i < 5; i++) step();
        check("t3_ovf_sticky", overflow, 1);
        do_reset();
        check("t3_ovf_rst", overflow, 0);

        // Branch condition then memory result
        alu_num = 4; alu_value = 0; alu_is_branch = 1;
        step();
        idle();
        await_wb("t4_tag", 4);
        check("t4_branch", wb_is_branch, 1);
        check("t4_value", wb_value, 0);
        mem_num = 6; mem_value = 32'h55;
        step();
        idle();
        await_wb("t4_mem_tag", 6);
        check("t4_mem_branch", wb_is_branch, 0);

        // Queue up both producers, then flush
        do_reset();
        for (int i = 0; i < 3; i++) begin
            alu_num = 3'(5 + i % 3); alu_value = $urandom;
            mem_num = 3'(5 + i % 3); mem_value = $urandom;
            step();
        end
        flush = 1;
        alu_num = 1; mem_num = 1;
        step();
        idle();
        check("t5_num", wb_num, 0);
        check("t5_astall", alu_stall, 0);
        check("t5_mstall", mem_stall, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("t5_drain", wb_num, 0);
        end

        // Reset mid-stream
        for (int i = 0; i < 2; i++) begin
            alu_num = 3; alu_value = $urandom;
            mem_num = 3; mem_value = $urandom;
            step();
        end
        rst = 1;
        step();
        rst = 0;
        idle();
        check_reset_values("t6");
        alu_num = 1; mem_num = 2;
        step();
        idle();
        await_wb("t6_tie", 1);

        // Randomized traffic, occasionally ignoring stall, with sporadic flush and reset
        for (int c = 0; c < 600; c++) begin
            rst   = ($urandom_range(0, 149) == 0);
            flush = ($urandom_range(0, 39) == 0);
            alu_value = $urandom; alu_is_branch = 1'($urandom_range(0, 1));
            mem_value = $urandom;
            if ($urandom_range(0, 2) != 0 && (!alu_stall || $urandom_range(0, 7) == 0))
                alu_num = 3'($urandom_range(1, 7));
            else
                alu_num = 0;
            if ($urandom_range(0, 2) != 0 && (!mem_stall || $urandom_range(0, 7) == 0))
                mem_num = 3'($urandom_range(1, 7));
            else
                mem_num = 0;
            step();
        end
        rst = 0;
        idle();
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
